or_bus_arbiter: RTL and testbench
=================================

Name: or_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared wired-OR data bus.
- The bus is built from OR2X2 trees: each requester's data word is AND-gated by its grant, and all gated words are OR-reduced onto one bus.
- The block guarantees at most one grant at a time and inserts a one-cycle turnaround between owners, so the OR tree never merges two sources.
- It sits between several requesters (DMA, debug, core ports) and a single downstream consumer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width per requester and of the bus.
- HOLD_MAX, 16, maximum consecutive grant cycles per owner. Used only with BUS_TIMEOUT_EN.

Ports:
- CLK  input  1  rising-edge clock.
- nRST  input  1  reset; synchronous, active-low.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- din  input  NREQ*WIDTH  requester data; requester i occupies din[i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot or zero grant, registered.
- owner  output  clog2(NREQ)  index of the current grantee; valid only while busy=1.
- busy  output  1  high while any gnt bit is set.
- bus  output  WIDTH  registered OR of (din[i] AND gnt[i]) over all i.
- bus_vld  output  1  bus carries owner data.

Behaviour:
- Reset (nRST=0 sampled at a CLK edge):
  - gnt=0, owner=0, busy=0, bus=0, bus_vld=0.
  - state=IDLE, priority pointer ptr=0, hold counter=0.
  - Reset overrides everything, including mid-grant; all outputs are cleared at that edge.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req≠0, the winner is the first i with req[i]=1, searching ptr, ptr+1, ... with wrap modulo NREQ.
  - At the next edge: gnt=onehot(winner), owner=winner, busy=1, state=GRANT.
  - Grant latency is one cycle from req sampled high.
  - If req=0, stay in IDLE with all outputs 0.
- GRANT:
  - Each edge: bus <= OR_i(din[i] & gnt[i]) and bus_vld <= 1. Bus data therefore lags din by one cycle.
  - The first bus_vld cycle is the cycle after gnt rises.
  - Stay in GRANT while req[owner]=1. Requests from non-owners are ignored (non-preemptive).
  - When req[owner] is sampled 0:
    - gnt=0, busy=0, state=TURN.
    - ptr = (owner+1) mod NREQ.
    - bus_vld stays 1 for this final edge, carrying the last data.
- TURN (exactly one cycle):
  - bus <= 0, bus_vld <= 0, gnt held at 0.
  - Arbitration runs here using the updated ptr. If req≠0, the winner is granted at the next edge (state=GRANT). Otherwise the state goes to IDLE.
  - Minimum gap between two owners' grants is therefore exactly one cycle.
- Boundary conditions:
  - Owner drops req in the same cycle others raise theirs: normal TURN, then the new winner is chosen by the updated ptr.
  - Former owner re-requests immediately: it is lowest priority in the next arbitration; it wins only if no other req is set.
  - All NREQ requesting continuously: grants rotate 0,1,2,...,NREQ-1,0 with one TURN cycle between each.
  - Pointer wrap: owner=NREQ-1 sets ptr=0.
  - Only one requester ever active: it is regranted after each TURN.
- Invariants:
  - popcount(gnt) ≤ 1 at all times.
  - gnt≠0 implies busy=1 and gnt[owner]=1.
  - bus=0 whenever bus_vld=0.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - A hold counter (clog2(HOLD_MAX+1) bits) clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches HOLD_MAX, the grant is forcibly released even if req[owner]=1. The block enters TURN with ptr=(owner+1) mod NREQ.
  - The owner may continue requesting and is rearbitrated at lowest priority.
  - An owner therefore holds gnt for at most HOLD_MAX cycles.
- BUS_TIMEOUT_EN undefined: no counter; HOLD_MAX is ignored; a grant persists as long as req[owner]=1.

Test Plan:
- Reset then idle: nRST=0 for 2 cycles, then req=0 for 10 cycles -> gnt=0, busy=0, bus=0, bus_vld=0 throughout.
- Single requester: req=4'b0100, din[2]=8'hA5 held for 5 cycles, then req=0 -> gnt=4'b0100 one cycle after req; bus=8'hA5 with bus_vld=1 the cycle after gnt; one TURN cycle with bus=0; ptr=3.
- Full round-robin: req=4'b1111 held, din[i]=8'h10+i, and each owner drops its req for one cycle after 3 granted cycles -> grant order 0,1,2,3,0; exactly one zero-gnt cycle between owners; bus values 10,11,12,13,10; never two gnt bits set.
- Non-preemption and wrap: requester 3 owns the bus; req[0] and req[1] rise mid-grant -> no change until req[3] drops; next grant goes to 0 (ptr wrapped to 0).
- Reset mid-grant: nRST=0 while gnt=4'b0010 and bus_vld=1 -> the next edge clears all outputs; after release with req=4'b0010, the grant returns in one cycle starting from ptr=0.
- Timeout (BUS_TIMEOUT_EN, HOLD_MAX=4): req[1] and req[2] held high continuously -> gnt[1] for exactly 4 cycles, TURN, gnt[2] for 4 cycles, TURN, gnt[1] again; without the macro, gnt[1] stays high indefinitely.

Source files
------------

// File: rtl/or_bus_arbiter.sv
// or_bus_arbiter
// Round-robin arbiter and sequencer for a shared wired-OR data bus.
// Each requester's word is AND-gated by its grant and all gated words are
// OR-reduced onto one registered bus. At most one grant is ever active, and
// a one-cycle turnaround separates consecutive owners so the OR tree never
// merges two sources.
//
// Optional feature: define BUS_TIMEOUT_EN to cap every grant at HOLD_MAX
// consecutive cycles. Without it, HOLD_MAX is ignored and a grant lasts for
// as long as the owner keeps requesting.
module or_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     din,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic [WIDTH-1:0]          bus,
  output logic                      bus_vld
);

  localparam int OWN_W = $clog2(NREQ);

  // Arbitration states; TURN is the single dead cycle between owners.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // Reject parameter values the round-robin search and counters are not sized for.
  if (NREQ < 2 || NREQ > 8) begin : g_badNreq
    $error("or_bus_arbiter: NREQ must lie in 2..8");
  end
  if (HOLD_MAX < 1) begin : g_badHoldMax
    $error("or_bus_arbiter: HOLD_MAX must be at least 1");
  end

  logic [1:0]       r_state;
  logic [OWN_W-1:0] r_ptr;
  logic [OWN_W-1:0] r_owner;
  logic [NREQ-1:0]  r_gnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_bus;
  logic             r_busVld;

  logic             w_anyReq;
  logic [OWN_W-1:0] w_winner;
  logic [NREQ-1:0]  w_winnerOneHot;
  logic [OWN_W-1:0] w_ptrNext;
  logic [WIDTH-1:0] w_busNext;
  logic             w_ownerReq;
  logic             w_timeout;
  logic             w_release;

  assign w_anyReq       = |req;
  assign w_winnerOneHot = NREQ'(1) << w_winner;
  assign w_ownerReq     = req[r_owner];

  // Priority pointer after the current owner, wrapping for any NREQ (not just powers of two).
  assign w_ptrNext = (r_owner == OWN_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  // Round-robin search: scanning from the highest offset down lets the
  // requester closest to ptr overwrite the others, so it wins.
  always_comb begin
    w_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(r_ptr) + k) % NREQ]) begin
        w_winner = OWN_W'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // The wired-OR bus: every word gated by its grant bit, then OR-reduced.
  always_comb begin
    w_busNext = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_busNext = w_busNext | (din[i*WIDTH +: WIDTH] & {WIDTH{r_gnt[i]}});
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_holdNext;

  assign w_holdNext = r_hold + 1'b1;
  assign w_timeout  = (w_holdNext == HOLD_W'(HOLD_MAX));

  // Hold counter sits at zero outside GRANT so it starts fresh on every grant
  // and counts one per granted cycle; reaching HOLD_MAX forces a release.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_hold <= '0;
    end else if (r_state != ST_GRANT) begin
      r_hold <= '0;
    end else begin
      r_hold <= w_holdNext;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_release = !w_ownerReq || w_timeout;

  // Grant sequencer: IDLE/TURN arbitrate, GRANT holds non-preemptively until
  // the owner lets go (or is timed out), then always passes through TURN.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_TURN: begin
          if (w_anyReq) begin
            r_gnt   <= w_winnerOneHot;
            r_owner <= w_winner;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end else begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_ptrNext;
            r_state <= ST_TURN;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus register: captures gated data on every GRANT cycle (including the
  // releasing one) and is forced to zero everywhere else.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_bus    <= '0;
      r_busVld <= 1'b0;
    end else if (r_state == ST_GRANT) begin
      r_bus    <= w_busNext;
      r_busVld <= 1'b1;
    end else begin
      r_bus    <= '0;
      r_busVld <= 1'b0;
    end
  end

  assign gnt     = r_gnt;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign bus     = r_bus;
  assign bus_vld = r_busVld;

`ifndef SYNTHESIS
  // Structural invariants of the bus protocol.
  a_gntOneHot0: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(r_gnt));
  a_gntBusy:    assert property (@(posedge CLK) disable iff (!nRST)
                                 (r_gnt != '0) |-> (r_busy && r_gnt[r_owner]));
  a_busQuiet:   assert property (@(posedge CLK) disable iff (!nRST)
                                 !r_busVld |-> (r_bus == '0));
`endif

endmodule

// File: tb/tb_or_bus_arbiter.sv
// tb_or_bus_arbiter
// Self-checking bench for or_bus_arbiter (NREQ=4, WIDTH=8, HOLD_MAX=4).
// A cycle model pushes the expected outputs into a queue at every rising
// edge; a checker pops them on the falling edge and compares. Directed
// checks with hand-derived constants cover the scenario-specific behaviour.
// Honors BUS_TIMEOUT_EN the same way the design does.
module tb_or_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic                  CLK;
  logic                  nRST;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [1:0]            owner;
  logic                  busy;
  logic [WIDTH-1:0]      bus;
  logic                  bus_vld;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] bus;
    logic       vld;
  } expT;

  expT expQ[$];

  int testsRun    = 0;
  int testsFailed = 0;

  int mState;
  int mPtr;
  int mOwner;
  int mHold;
  logic [3:0] mGnt;
  logic       mBusy;
  logic [7:0] mBus;
  logic       mVld;

  int expOrder[5] = '{0, 1, 2, 3, 0};

  or_bus_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .HOLD_MAX(HOLD_MAX)
  ) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .req    (req),
    .din    (din),
    .gnt    (gnt),
    .owner  (owner),
    .busy   (busy),
    .bus    (bus),
    .bus_vld(bus_vld)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelGrant();
    for (int k = 0; k < NREQ; k++) begin
      int w = (mPtr + k) % NREQ;
      if (req[w]) begin
        mGnt   = 4'(1 << w);
        mOwner = w;
        mBusy  = 1'b1;
        mHold  = 0;
        mState = 1;
        return;
      end
    end
    mState = 0;
  endtask

  // Reference model: predicts the registered outputs produced by each rising edge.
  always @(posedge CLK) begin
    expT e;
    if (!nRST) begin
      mState = 0; mPtr = 0; mOwner = 0; mHold = 0;
      mGnt = '0; mBusy = 1'b0; mBus = '0; mVld = 1'b0;
    end else begin
      case (mState)
        1: begin
          mBus = din[mOwner*WIDTH +: WIDTH];
          mVld = 1'b1;
          mHold++;
          if (!req[mOwner] || (TIMEOUT_ON && mHold == HOLD_MAX)) begin
            mGnt   = '0;
            mBusy  = 1'b0;
            mPtr   = (mOwner + 1) % NREQ;
            mState = 2;
          end
        end
        default: begin
          mBus = '0;
          mVld = 1'b0;
          modelGrant();
        end
      endcase
    end
    e.gnt   = mGnt;
    e.owner = 2'(mOwner);
    e.busy  = mBusy;
    e.bus   = mBus;
    e.vld   = mVld;
    expQ.push_back(e);
  end

  // Scoreboard checker: compares DUT outputs against the model on the falling edge.
  always @(negedge CLK) begin
    expT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("gnt", 32'(gnt), 32'(e.gnt));
      checkOutput("busy", 32'(busy), 32'(e.busy));
      checkOutput("bus", 32'(bus), 32'(e.bus));
      checkOutput("bus_vld", 32'(bus_vld), 32'(e.vld));
      if (e.busy) checkOutput("owner", 32'(owner), 32'(e.owner));
      checkOutput("gntOnehot0", 32'($onehot0(gnt)), 32'd1);
      if (!bus_vld) checkOutput("busQuiet", 32'(bus), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input int cycles);
    req = r;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic waitGrant(output int who);
    int n = 0;
    who = -1;
    while (gnt == '0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("grantArrived", 32'(gnt != '0), 32'd1);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) who = i;
    end
  endtask

  // Directed scenarios driven on falling edges.
  initial begin
    int who;
    int runLen;
    nRST = 1'b0;
    req  = '0;
    din  = '0;

    // Reset then idle.
    repeat (2) @(negedge CLK);
    checkOutput("resetGnt", 32'(gnt), 32'd0);
    checkOutput("resetOwner", 32'(owner), 32'd0);
    checkOutput("resetBusVld", 32'(bus_vld), 32'd0);
    nRST = 1'b1;
    applyStimulus(4'b0000, 10);
    checkOutput("idleBusy", 32'(busy), 32'd0);

    // Single requester 2 with 8'hA5.
    din[2*WIDTH +: WIDTH] = 8'hA5;
    applyStimulus(4'b0100, 1);
    checkOutput("singleGnt", 32'(gnt), 32'h4);
    @(negedge CLK);
    checkOutput("singleBus", 32'(bus), 32'hA5);
    checkOutput("singleVld", 32'(bus_vld), 32'd1);
    applyStimulus(4'b0100, 2);
    applyStimulus(4'b0000, 1);
    checkOutput("releaseGnt", 32'(gnt), 32'd0);
    checkOutput("releaseLastBus", 32'(bus), 32'hA5);
    applyStimulus(4'b0000, 1);
    checkOutput("turnVld", 32'(bus_vld), 32'd0);
    applyStimulus(4'b0000, 2);
    // ptr is now 3: requester 3 beats requester 0.
    applyStimulus(4'b1001, 1);
    checkOutput("ptrAfterSingle", 32'(gnt), 32'h8);
    applyStimulus(4'b0000, 3);

    // Full round-robin with every requester active.
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waitGrant(who);
      checkOutput("rrOrder", 32'(who), 32'(expOrder[g]));
      @(negedge CLK);
      checkOutput("rrBus", 32'(bus), 32'(8'h10 + expOrder[g]));
      @(negedge CLK);
      if (who >= 0) req[who] = 1'b0;
      @(negedge CLK);
      checkOutput("rrGap", 32'(gnt), 32'd0);
      if (who >= 0) req[who] = 1'b1;
    end
    applyStimulus(4'b0000, 4);

    // Non-preemption and pointer wrap.
    applyStimulus(4'b1000, 1);
    checkOutput("np3Gnt", 32'(gnt), 32'h8);
    applyStimulus(4'b1011, 2);
    checkOutput("noPreempt", 32'(gnt), 32'h8);
    applyStimulus(4'b0011, 1);
    checkOutput("npRelease", 32'(gnt), 32'd0);
    applyStimulus(4'b0011, 1);
    checkOutput("wrapGnt", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, 4);

    // Reset mid-grant.
    applyStimulus(4'b0010, 3);
    checkOutput("preResetVld", 32'(bus_vld), 32'd1);
    nRST = 1'b0;
    @(negedge CLK);
    checkOutput("midResetGnt", 32'(gnt), 32'd0);
    checkOutput("midResetBus", 32'(bus), 32'd0);
    checkOutput("midResetVld", 32'(bus_vld), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("postResetGnt", 32'(gnt), 32'h2);
    applyStimulus(4'b0000, 4);

    // Hold limit: requesters 1 and 2 held continuously from ptr=0.
    nRST = 1'b0;
    applyStimulus(4'b0000, 2);
    nRST = 1'b1;
    req  = 4'b0110;
    waitGrant(who);
    checkOutput("holdFirst", 32'(who), 32'd1);
    runLen = 0;
    while (gnt == 4'b0010 && runLen < 12) begin
      runLen++;
      @(negedge CLK);
    end
    checkOutput("holdLen", 32'(runLen), TIMEOUT_ON ? 32'd4 : 32'd12);
    applyStimulus(4'b0110, 12);
    applyStimulus(4'b0000, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
